// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//   Unsigned sequential restoring divider, one quotient bit per clock, MSB
//   first. Operands arrive over a valid/ready handshake; quotient and
//   remainder leave over a second valid/ready handshake and hold steady
//   until accepted. A zero divisor skips the iteration and returns
//   quotient = all ones, remainder = dividend, div_by_zero = 1.
//
//   Optional feature macro: MULT_CHECK_EN
//     When defined, the finished result is re-multiplied (q*d + r) and
//     compared with the latched dividend; a mismatch raises chk_err while
//     out_valid is high. When undefined, chk_err is constant 0.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   in_valid     in   1      dividend/divisor valid
//   in_ready     out  1      block can accept an operation (IDLE only)
//   dividend     in   WIDTH  unsigned numerator
//   divisor      in   WIDTH  unsigned denominator
//   out_valid    out  1      quotient/remainder valid (DONE only)
//   out_ready    in   1      consumer accepts result
//   quotient     out  WIDTH  floor(dividend / divisor)
//   remainder    out  WIDTH  dividend mod divisor
//   div_by_zero  out  1      result came from divisor == 0
//   chk_err      out  1      self-check mismatch (MULT_CHECK_EN only)
// -----------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             chk_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q_reg;     // dividend shifts out MSB-first, quotient shifts in
    logic [WIDTH-1:0] r_reg;     // partial remainder, always < divisor between steps
    logic [WIDTH-1:0] d_reg;
    logic [CW-1:0]    count;
    logic             dz_reg;
    logic             accept;
    logic             last_step;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_step;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                if (last_step) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign accept    = in_valid && (state == IDLE);
    assign last_step = (state == RUN) && (count == CW'(1));

    // ---------------- one restoring step ----------------
    // The shifted remainder is WIDTH+1 bits; since r_reg < d_reg, the
    // difference always lies in signed WIDTH+1 range, so its top bit is a
    // reliable borrow. On borrow, shifted < divisor, so its top bit is 0.
    always_comb begin
        shifted = {r_reg, q_reg[WIDTH-1]};
        trial   = shifted - {1'b0, d_reg};
        if (trial[WIDTH]) begin
            r_step = shifted[WIDTH-1:0];
            q_step = {q_reg[WIDTH-2:0], 1'b0};
        end else begin
            r_step = trial[WIDTH-1:0];
            q_step = {q_reg[WIDTH-2:0], 1'b1};
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg  <= '0;
            r_reg  <= '0;
            d_reg  <= '0;
            count  <= '0;
            dz_reg <= 1'b0;
        end else if (accept) begin
            d_reg  <= divisor;
            dz_reg <= (divisor == '0);
            if (divisor == '0) begin
                q_reg <= '1;
                r_reg <= dividend;
                count <= '0;
            end else begin
                q_reg <= dividend;
                r_reg <= '0;
                count <= CW'(WIDTH);
            end
        end else if (state == RUN) begin
            q_reg <= q_step;
            r_reg <= r_step;
            count <= count - CW'(1);
        end
    end

    assign quotient    = q_reg;
    assign remainder   = r_reg;
    assign div_by_zero = dz_reg;

`ifdef MULT_CHECK_EN
    logic [WIDTH-1:0]   a_reg;
    logic               chk_reg;
    logic [2*WIDTH-1:0] recon;

    // Checked against the values being written on the final step, so the
    // flag is registered together with the result.
    assign recon = {{WIDTH{1'b0}}, q_step} * {{WIDTH{1'b0}}, d_reg}
                 + {{WIDTH{1'b0}}, r_step};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            chk_reg <= 1'b0;
        end else if (accept) begin
            a_reg   <= dividend;
            chk_reg <= 1'b0;
        end else if (last_step) begin
            chk_reg <= (recon != {{WIDTH{1'b0}}, a_reg});
        end
    end

    assign chk_err = chk_reg;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         chk_err;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int q;
        int r;
        int dz;
        int due;
    } exp_t;

    exp_t expq[$];
    bit   front_seen = 1'b0;

    // Handshakes are judged at the negedge: inputs change only #1 after a
    // posedge, so the values seen here are those sampled at the next edge.
    always @(negedge clk) begin
        exp_t e;
        int   a, d;
        if (rst) begin
            expq.delete();
            front_seen = 1'b0;
        end else begin
            if (in_ready && out_valid) check("ready_excl", 1, 0);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    if (!front_seen) begin
                        check("latency", cyc, expq[0].due);
                        front_seen = 1'b1;
                    end
                    check("quotient", int'(quotient), expq[0].q);
                    check("remainder", int'(remainder), expq[0].r);
                    check("div_by_zero", int'(div_by_zero), expq[0].dz);
                    check("chk_err", int'(chk_err), 0);
                    if (out_ready) begin
                        void'(expq.pop_front());
                        front_seen = 1'b0;
                    end
                end
            end else if (expq.size() > 0 && !front_seen && cyc == expq[0].due + 1) begin
                check("late_result", 0, 1);
            end
            if (in_valid && in_ready) begin
                a = int'(dividend);
                d = int'(divisor);
                if (d == 0) begin
                    e.q = (1 << W) - 1;
                    e.r = a;
                    e.dz = 1;
                    e.due = cyc + 1;
                end else begin
                    e.q = a / d;
                    e.r = a % d;
                    e.dz = 0;
                    e.due = cyc + W + 1;
                end
                expq.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int a, input int d);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            dividend = W'(a);
            divisor  = W'(d);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    typedef struct {
        int a;
        int d;
        int q;
        int r;
    } vec_t;

    vec_t vecs[4] = '{
        '{0, 5, 0, 0},
        '{15, 15, 1, 0},
        '{15, 1, 15, 0},
        '{5, 9, 0, 5}
    };

    initial begin
        int n;
        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_dz", int'(div_by_zero), 0);
        check("rst_chk_err", int'(chk_err), 0);
        rst = 1'b0;

        // 13/3 with backpressure
        ready_mode = 0;
        send(13, 3);
        wait_valid(n);
        check("lat_13_3", n + 1, 5);
        check("q_13_3", int'(quotient), 4);
        check("r_13_3", int'(remainder), 1);
        check("dz_13_3", int'(div_by_zero), 0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            dividend = 4'd2;
            divisor  = 4'd1;
            @(posedge clk); #1;
            check("bp_valid", int'(out_valid), 1);
            check("bp_q", int'(quotient), 4);
            check("bp_r", int'(remainder), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        ready_mode = 1;

        // divide by zero, then a normal op clears the flag
        send(7, 0);
        wait_valid(n);
        check("lat_7_0", n + 1, 1);
        check("q_7_0", int'(quotient), 15);
        check("r_7_0", int'(remainder), 7);
        check("dz_7_0", int'(div_by_zero), 1);
        send(6, 2);
        wait_valid(n);
        check("q_6_2", int'(quotient), 3);
        check("r_6_2", int'(remainder), 0);
        check("dz_6_2", int'(div_by_zero), 0);

        foreach (vecs[k]) begin
            send(vecs[k].a, vecs[k].d);
            wait_valid(n);
            check("vec_q", int'(quotient), vecs[k].q);
            check("vec_r", int'(remainder), vecs[k].r);
        end

        // reset during step 2 of 9/2
        send(9, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_q", int'(quotient), 0);
        check("abort_r", int'(remainder), 0);
        send(9, 2);
        wait_valid(n);
        check("q_9_2", int'(quotient), 4);
        check("r_9_2", int'(remainder), 1);

        // exhaustive sweep with random backpressure
        ready_mode = 2;
        for (int a = 0; a < (1 << W); a++)
            for (int d = 0; d < (1 << W); d++)
                send(a, d);

        n = 0;
        while (expq.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
